// File: rtl/bv_pkg.sv
// Shared constants, result payload and lowest-set-bit encoder for the bv_9_12 AND/encode stage.
// BV_MATCH_VEC_EN adds the full match vector to the result payload.
package bv_pkg;

    localparam int unsigned NUM_STAGES = 4;
    localparam int unsigned BV_W       = 36;
    localparam int unsigned IDX_W      = 6;
    localparam int unsigned CNT_W      = 16;

    typedef struct packed {
        logic             hit;
        logic [IDX_W-1:0] index;
`ifdef BV_MATCH_VEC_EN
        logic [BV_W-1:0]  vec;
`endif
    } bv_result_t;

    // Lowest set bit wins (highest-priority rule); 0 when the vector is empty.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [BV_W-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = BV_W - 1; i >= 0; i--) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/bv_and_encode_if.sv
// Result valid/ready bus between bv_and_encode and its consumer.
// BV_MATCH_VEC_EN adds res_vec.
interface bv_and_encode_if;
    import bv_pkg::*;

    logic             res_valid;
    logic             res_ready;
    logic             res_hit;
    logic [IDX_W-1:0] res_index;
`ifdef BV_MATCH_VEC_EN
    logic [BV_W-1:0]  res_vec;
`endif

    modport master (
`ifdef BV_MATCH_VEC_EN
        output res_vec,
`endif
        output res_valid,
        output res_hit,
        output res_index,
        input  res_ready
    );

    modport slave (
`ifdef BV_MATCH_VEC_EN
        input  res_vec,
`endif
        input  res_valid,
        input  res_hit,
        input  res_index,
        output res_ready
    );

endinterface

// File: rtl/bv_result_fifo.sv
// Show-ahead FIFO with extra-MSB pointers; rdata reads zero while empty.
module bv_result_fifo #(
    parameter int unsigned WIDTH = 7,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_pop;
    logic             w_push;

    // A push on a full FIFO is only legal when the head leaves in the same cycle.
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign rdata = empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/bv_and_encode.sv
// Aligns stage strobes, ANDs the stage bit vectors, priority-encodes and queues results.
// BV_MATCH_VEC_EN also carries the full match vector to res_vec.
module bv_and_encode
    import bv_pkg::*;
#(
    parameter int unsigned ALIGN_DLY  = 1,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_STAGES-1:0]      stage_enable,
    input  logic [NUM_STAGES*BV_W-1:0] bv_in,
    bv_and_encode_if.master            res,
    output logic                       fifo_full,
    output logic [CNT_W-1:0]           drop_cnt,
    output logic [CNT_W-1:0]           align_err_cnt
);

    localparam int unsigned RES_W = $bits(bv_result_t);

    logic [NUM_STAGES-1:0] w_en_d;
    logic [BV_W-1:0]       w_and;
    logic                  r_v1;
    logic [BV_W-1:0]       r_and_vec;
    logic                  r_v2;
    logic                  r_hit2;
    logic [IDX_W-1:0]      r_idx2;
`ifdef BV_MATCH_VEC_EN
    logic [BV_W-1:0]       r_vec2;
`endif
    logic [CNT_W-1:0]      r_drop_cnt;
    logic [CNT_W-1:0]      r_align_err_cnt;
    bv_result_t            w_wdata;
    bv_result_t            w_rdata;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;

    // S0: per-bit strobe delay so en_d lines up with the stage vectors.
    generate
        if (ALIGN_DLY == 0) begin : g_no_align
            assign w_en_d = stage_enable;
        end else begin : g_align
            logic [ALIGN_DLY-1:0][NUM_STAGES-1:0] r_en_sr;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_en_sr <= '0;
                end else begin
                    r_en_sr[0] <= stage_enable;
                    for (int k = 1; k < int'(ALIGN_DLY); k++) r_en_sr[k] <= r_en_sr[k-1];
                end
            end
            assign w_en_d = r_en_sr[ALIGN_DLY-1];
        end
    endgenerate

    always_comb begin
        w_and = '1;
        for (int i = 0; i < int'(NUM_STAGES); i++) w_and &= bv_in[i*BV_W +: BV_W];
    end

    // S1 merge and S2 encode; a partial strobe set is an alignment error, not a lookup.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v1            <= 1'b0;
            r_and_vec       <= '0;
            r_v2            <= 1'b0;
            r_hit2          <= 1'b0;
            r_idx2          <= '0;
`ifdef BV_MATCH_VEC_EN
            r_vec2          <= '0;
`endif
            r_align_err_cnt <= '0;
        end else begin
            r_v1 <= &w_en_d;
            if (&w_en_d) begin
                r_and_vec <= w_and;
            end else if (|w_en_d) begin
                if (r_align_err_cnt != '1) r_align_err_cnt <= r_align_err_cnt + CNT_W'(1);
            end
            r_v2 <= r_v1;
            if (r_v1) begin
                r_hit2 <= |r_and_vec;
                r_idx2 <= lowest_set(r_and_vec);
`ifdef BV_MATCH_VEC_EN
                r_vec2 <= r_and_vec;
`endif
            end
        end
    end

    assign w_pop  = ~w_empty & res.res_ready;
    assign w_push = r_v2 & (~w_full | w_pop);
    assign w_drop = r_v2 & w_full & ~w_pop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_wdata       = '0;
        w_wdata.hit   = r_hit2;
        w_wdata.index = r_idx2;
`ifdef BV_MATCH_VEC_EN
        w_wdata.vec   = r_vec2;
`endif
    end

    bv_result_fifo #(
        .WIDTH (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .wdata (w_wdata),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty)
    );

    assign res.res_valid = ~w_empty;
    assign res.res_hit   = w_rdata.hit;
    assign res.res_index = w_rdata.index;
`ifdef BV_MATCH_VEC_EN
    assign res.res_vec   = w_rdata.vec;
`endif
    assign fifo_full     = w_full;
    assign drop_cnt      = r_drop_cnt;
    assign align_err_cnt = r_align_err_cnt;

endmodule

// File: tb/tb_bv_and_encode.sv
// Scoreboard bench for bv_and_encode: a queue-based FIFO model predicts accepted results and drops.
module tb_bv_and_encode;
    import bv_pkg::*;

    localparam int unsigned ALIGN_DLY  = 1;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int          LAT        = int'(ALIGN_DLY) + 2;  // issue cycle to FIFO write cycle

    typedef struct {
        int          due;
        logic        hit;
        logic [5:0]  idx;
        logic [35:0] vec;
    } exp_t;

    logic                       clk;
    logic                       reset;
    logic [NUM_STAGES-1:0]      stage_enable;
    logic [NUM_STAGES*BV_W-1:0] bv_in;
    logic                       fifo_full;
    logic [CNT_W-1:0]           drop_cnt;
    logic [CNT_W-1:0]           align_err_cnt;

    bv_and_encode_if res_if ();

    bv_and_encode #(
        .ALIGN_DLY  (ALIGN_DLY),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stage_enable  (stage_enable),
        .bv_in         (bv_in),
        .res           (res_if),
        .fifo_full     (fifo_full),
        .drop_cnt      (drop_cnt),
        .align_err_cnt (align_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int           n_chk  = 0;
    int           n_fail = 0;
    int           n_pop  = 0;
    int           cyc    = 0;
    int           exp_drop = 0;
    int           exp_err  = 0;
    exp_t         pend_q[$];
    exp_t         exp_q[$];
    logic [143:0] nxt_bv;
    logic [35:0]  ones = 36'hF_FFFF_FFFF;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Reference: AND of the four slices, lowest set bit as the rule index.
    function automatic exp_t ref_result(input logic [143:0] s, input int due);
        exp_t e;
        e.due = due;
        e.vec = s[35:0] & s[71:36] & s[107:72] & s[143:108];
        e.hit = (e.vec != 36'h0);
        e.idx = 6'd0;
        for (int i = 0; i < 36; i++) begin
            if (e.vec[i]) begin
                e.idx = 6'(i);
                break;
            end
        end
        return e;
    endfunction

    // Drive one cycle: strobes now, their vectors next cycle; model FIFO occupancy for writes due now.
    task automatic cycle(input logic [3:0] en, input logic [143:0] sl, input logic rdy);
        exp_t e;
        int   occ;
        @(posedge clk);
        #1;
        cyc++;
        stage_enable     = en;
        bv_in            = nxt_bv;
        res_if.res_ready = rdy;
        nxt_bv           = sl;
        if (en == 4'hF)      pend_q.push_back(ref_result(sl, cyc + LAT));
        else if (en != 4'h0) exp_err++;
        while (pend_q.size() > 0 && pend_q[0].due == cyc) begin
            e   = pend_q.pop_front();
            occ = exp_q.size();
            if (occ < int'(FIFO_DEPTH) || (rdy && occ > 0)) exp_q.push_back(e);
            else exp_drop++;
        end
    endtask

    function automatic logic [143:0] rand_slices();
        logic [63:0]  a, b, t;
        logic [143:0] s;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        t = a & b & {$urandom, $urandom} & {$urandom, $urandom};
        for (int i = 0; i < 4; i++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            s[i*36 +: 36] = t[35:0] | (a[35:0] & b[35:0]);
        end
        return s;
    endfunction

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(4'h0, rand_slices(), rdy);
    endtask

    // Monitor: every accepted head is compared against the oldest expected result.
    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && res_if.res_valid === 1'b1 && res_if.res_ready === 1'b1) begin
            n_pop++;
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_result: got hit=%0b idx=%0d expected no result",
                         res_if.res_hit, res_if.res_index);
            end else begin
                e = exp_q.pop_front();
                if (res_if.res_hit !== e.hit || res_if.res_index !== e.idx) begin
                    n_fail++;
                    $display("FAIL result: got hit=%0b idx=%0d expected hit=%0b idx=%0d",
                             res_if.res_hit, res_if.res_index, e.hit, e.idx);
                end
`ifdef BV_MATCH_VEC_EN
                n_chk++;
                if (res_if.res_vec !== e.vec) begin
                    n_fail++;
                    $display("FAIL res_vec: got %0h expected %0h", res_if.res_vec, e.vec);
                end
`endif
            end
        end
    end

    initial begin
        reset            = 1'b0;
        stage_enable     = '0;
        bv_in            = '0;
        res_if.res_ready = 1'b0;
        nxt_bv           = '0;
        #23;
        chk("rst_valid", 64'(res_if.res_valid), 64'(0));
        chk("rst_hit", 64'(res_if.res_hit), 64'(0));
        chk("rst_index", 64'(res_if.res_index), 64'(0));
        chk("rst_full", 64'(fifo_full), 64'(0));
        chk("rst_drop", 64'(drop_cnt), 64'(0));
        chk("rst_alerr", 64'(align_err_cnt), 64'(0));
        reset = 1'b1;
        idle(2, 1'b0);

        // Latency: all-ones lookup, result visible LAT+1 cycles after issue.
        cycle(4'hF, {ones, ones, ones, ones}, 1'b0);
        idle(3, 1'b0);
        @(negedge clk);
        chk("lat_early", 64'(res_if.res_valid), 64'(0));
        idle(1, 1'b0);
        @(negedge clk);
        chk("lat_valid", 64'(res_if.res_valid), 64'(1));
        chk("lat_hit", 64'(res_if.res_hit), 64'(1));
        chk("lat_index", 64'(res_if.res_index), 64'(0));
        idle(3, 1'b1);

        // Directed index boundaries and a miss, back to back.
        cycle(4'hF, {ones, ones, ones, 36'h0_0000_0100}, 1'b1);
        cycle(4'hF, {ones, ones, ones, 36'h8_0000_0000}, 1'b1);
        cycle(4'hF, {ones, ones, 36'h0_0000_0002, 36'h0_0000_0001}, 1'b1);
        idle(8, 1'b1);

        // Overflow: 10 lookups with the consumer stalled.
        for (int i = 0; i < 10; i++) cycle(4'hF, rand_slices(), 1'b0);
        idle(6, 1'b0);
        @(negedge clk);
        chk("ovf_full", 64'(fifo_full), 64'(1));
        chk("ovf_drop", 64'(drop_cnt), 64'(exp_drop));
        chk("ovf_drop2", 64'(drop_cnt), 64'(2));
        n_pop = 0;
        idle(12, 1'b1);
        @(negedge clk);
        chk("drain_count", 64'(n_pop), 64'(8));
        chk("drain_valid", 64'(res_if.res_valid), 64'(0));
        chk("drain_full", 64'(fifo_full), 64'(0));

        // Partial strobe set: error counted, no result; next full strobe works.
        n_pop = 0;
        cycle(4'b0111, rand_slices(), 1'b1);
        idle(6, 1'b1);
        @(negedge clk);
        chk("alerr_cnt", 64'(align_err_cnt), 64'(1));
        chk("alerr_nores", 64'(n_pop), 64'(0));
        cycle(4'hF, {ones, ones, ones, 36'h0_0001_0000}, 1'b1);
        idle(6, 1'b1);
        @(negedge clk);
        chk("alerr_next", 64'(n_pop), 64'(1));

        // Random traffic with random backpressure.
        for (int i = 0; i < 300; i++) begin
            logic [3:0] en;
            int unsigned r;
            r  = $urandom_range(0, 9);
            en = (r < 8) ? 4'hF : (r == 8) ? 4'h0 : 4'($urandom_range(1, 14));
            cycle(en, rand_slices(), ($urandom_range(0, 3) != 0));
        end
        idle(20, 1'b1);
        @(negedge clk);
        chk("rnd_drop", 64'(drop_cnt), 64'(exp_drop));
        chk("rnd_alerr", 64'(align_err_cnt), 64'(exp_err));
        chk("rnd_sb_empty", 64'(exp_q.size() + pend_q.size()), 64'(0));
        chk("rnd_valid", 64'(res_if.res_valid), 64'(0));

        // Reset with three queued and two in flight.
        for (int i = 0; i < 5; i++) cycle(4'hF, rand_slices(), 1'b0);
        idle(1, 1'b0);
        @(negedge clk);
        chk("pre_rst_valid", 64'(res_if.res_valid), 64'(1));
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(res_if.res_valid), 64'(0));
        chk("mid_rst_hit", 64'(res_if.res_hit), 64'(0));
        chk("mid_rst_index", 64'(res_if.res_index), 64'(0));
        chk("mid_rst_full", 64'(fifo_full), 64'(0));
        chk("mid_rst_drop", 64'(drop_cnt), 64'(0));
        chk("mid_rst_alerr", 64'(align_err_cnt), 64'(0));
        exp_q.delete();
        pend_q.delete();
        exp_drop = 0;
        exp_err  = 0;
        nxt_bv   = '0;
        @(negedge clk);
        #2;
        reset = 1'b1;
        n_pop = 0;
        idle(10, 1'b1);
        @(negedge clk);
        chk("post_rst_nostale", 64'(n_pop), 64'(0));
        chk("post_rst_valid", 64'(res_if.res_valid), 64'(0));
        cycle(4'hF, {ones, ones, ones, 36'h0_0000_0400}, 1'b1);
        idle(6, 1'b1);
        @(negedge clk);
        chk("post_rst_lookup", 64'(n_pop), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
